// File: rtl/pc_src_sequencer_pkg.sv
// Shared encodings for the PC-source sequencer: mux codes, cause codes, vectors, states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package pc_src_sequencer_pkg;

  // PC-source mux selector codes (110/111 are never driven)
  localparam logic [2:0] PCSRC_INC    = 3'b000;
  localparam logic [2:0] PCSRC_BRANCH = 3'b001;
  localparam logic [2:0] PCSRC_JUMP   = 3'b010;
  localparam logic [2:0] PCSRC_EPC    = 3'b011;
  localparam logic [2:0] PCSRC_IMM    = 3'b100;
  localparam logic [2:0] PCSRC_MEM    = 3'b101;

  // Exception cause codes; these double as the vector-address mux select
  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_OPC  = 2'b01;
  localparam logic [1:0] CAUSE_OVF  = 2'b10;
  localparam logic [1:0] CAUSE_DIV0 = 2'b11;

  // Handler vector byte addresses selected by vec_sel
  localparam logic [7:0] VEC_ADDR_OPC  = 8'd253;
  localparam logic [7:0] VEC_ADDR_OVF  = 8'd254;
  localparam logic [7:0] VEC_ADDR_DIV0 = 8'd255;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_UPD      = 3'd1,
    ST_EXC_EPC  = 3'd2,
    ST_EXC_RD   = 3'd3,
    ST_EXC_LOAD = 3'd4
  } state_t;

  // Vector byte address that the memory address mux presents for a given cause
  function automatic logic [7:0] vec_addr(input logic [1:0] cause);
    case (cause)
      CAUSE_OPC:  vec_addr = VEC_ADDR_OPC;
      CAUSE_OVF:  vec_addr = VEC_ADDR_OVF;
      CAUSE_DIV0: vec_addr = VEC_ADDR_DIV0;
      default:    vec_addr = 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/pc_src_sequencer_exc_priority_enc.sv
// Fixed-priority encoder of the three exception events into a 2-bit cause.
// Latency: combinational.
// Backpressure: none.
module exc_priority_enc
  import pc_src_sequencer_pkg::*;
(
  input  logic       i_opc,
  input  logic       i_ovf,
  input  logic       i_div0,
  output logic [1:0] o_cause,
  output logic       o_any
);

  // Invalid opcode beats overflow beats divide-by-zero
  always_comb begin
    o_cause = CAUSE_NONE;
    if (i_opc)       o_cause = CAUSE_OPC;
    else if (i_ovf)  o_cause = CAUSE_OVF;
    else if (i_div0) o_cause = CAUSE_DIV0;
    o_any = i_opc | i_ovf | i_div0;
  end

endmodule

// File: rtl/pc_src_sequencer.sv
// Sequences PC/EPC writes: one-cycle PC updates and the EPC-save / vector-fetch / PC-load exception entry.
// Latency: 1 cycle for a normal update, 2+MEM_LAT cycles for exception entry.
// Backpressure: inputs sampled only in IDLE; anything asserted while busy is ignored, not queued.
module pc_src_sequencer
  import pc_src_sequencer_pkg::*;
#(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_inc,
  input  logic       req_branch,
  input  logic       req_jump,
  input  logic       req_rte,
  input  logic       req_imm,
  input  logic       exc_opcode,
  input  logic       exc_ovf,
  input  logic       exc_div0,
  output logic [2:0] pc_src_sel,
  output logic       pc_write,
  output logic       epc_write,
  output logic [1:0] vec_sel,
  output logic       mem_rd,
  output logic [1:0] exc_cause,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] CNT_LOAD = 3'(MEM_LAT - 1);

  state_t     r_state;
  logic [2:0] r_cnt;
  logic [2:0] r_pc_src_sel;
  logic       r_pc_write;
  logic       r_epc_write;
  logic [1:0] r_vec_sel;
  logic       r_mem_rd;
  logic [1:0] r_exc_cause;
  logic       r_busy;
  logic       r_done;

  logic [1:0] w_cause;
  logic       w_exc_any;
  logic [2:0] w_req_sel;
  logic       w_req_any;

  exc_priority_enc u_exc_enc (
    .i_opc   (exc_opcode),
    .i_ovf   (exc_ovf),
    .i_div0  (exc_div0),
    .o_cause (w_cause),
    .o_any   (w_exc_any)
  );

  // Pick the winning normal request: rte > jump > branch > imm > inc
  always_comb begin
    w_req_sel = PCSRC_INC;
    w_req_any = 1'b1;
    if (req_rte)         w_req_sel = PCSRC_EPC;
    else if (req_jump)   w_req_sel = PCSRC_JUMP;
    else if (req_branch) w_req_sel = PCSRC_BRANCH;
    else if (req_imm)    w_req_sel = PCSRC_IMM;
    else if (req_inc)    w_req_sel = PCSRC_INC;
    else                 w_req_any = 1'b0;
  end

  // Sequencer FSM with registered outputs; pulses default low every cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 3'd0;
      r_pc_src_sel <= PCSRC_INC;
      r_pc_write   <= 1'b0;
      r_epc_write  <= 1'b0;
      r_vec_sel    <= CAUSE_NONE;
      r_mem_rd     <= 1'b0;
      r_exc_cause  <= CAUSE_NONE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_pc_write  <= 1'b0;
      r_epc_write <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_exc_any) begin
            r_state     <= ST_EXC_EPC;
            r_exc_cause <= w_cause;
            r_epc_write <= 1'b1;
            r_busy      <= 1'b1;
          end else if (w_req_any) begin
            r_state      <= ST_UPD;
            r_pc_src_sel <= w_req_sel;
            r_pc_write   <= 1'b1;
            r_done       <= 1'b1;
            r_busy       <= 1'b1;
          end
        end
        ST_UPD: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        ST_EXC_EPC: begin
          // EPC was captured this cycle; start the vector byte read
          r_state   <= ST_EXC_RD;
          r_cnt     <= CNT_LOAD;
          r_mem_rd  <= 1'b1;
          r_vec_sel <= r_exc_cause;
        end
        ST_EXC_RD: begin
          if (r_cnt == 3'd0) begin
            // Vector byte is valid on the memory output: load it into PC
            r_state      <= ST_EXC_LOAD;
            r_mem_rd     <= 1'b0;
            r_pc_src_sel <= PCSRC_MEM;
            r_pc_write   <= 1'b1;
            r_done       <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        ST_EXC_LOAD: begin
          r_state   <= ST_IDLE;
          r_busy    <= 1'b0;
          r_vec_sel <= CAUSE_NONE;
        end
        default: begin
          r_state   <= ST_IDLE;
          r_busy    <= 1'b0;
          r_mem_rd  <= 1'b0;
          r_vec_sel <= CAUSE_NONE;
        end
      endcase
    end
  end

  assign pc_src_sel = r_pc_src_sel;
  assign pc_write   = r_pc_write;
  assign epc_write  = r_epc_write;
  assign vec_sel    = r_vec_sel;
  assign mem_rd     = r_mem_rd;
  assign exc_cause  = r_exc_cause;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_pc_src_sequencer.sv
// Directed, table-driven bench for pc_src_sequencer.
// Latency: n/a.
// Backpressure: n/a.
module tb_pc_src_sequencer;

  localparam int unsigned LAT = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_inc, req_branch, req_jump, req_rte, req_imm;
  logic       exc_opcode, exc_ovf, exc_div0;
  logic [2:0] pc_src_sel;
  logic       pc_write, epc_write, mem_rd, busy, done;
  logic [1:0] vec_sel, exc_cause;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pc_src_sequencer #(.MEM_LAT(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_inc    (req_inc),
    .req_branch (req_branch),
    .req_jump   (req_jump),
    .req_rte    (req_rte),
    .req_imm    (req_imm),
    .exc_opcode (exc_opcode),
    .exc_ovf    (exc_ovf),
    .exc_div0   (exc_div0),
    .pc_src_sel (pc_src_sel),
    .pc_write   (pc_write),
    .epc_write  (epc_write),
    .vec_sel    (vec_sel),
    .mem_rd     (mem_rd),
    .exc_cause  (exc_cause),
    .busy       (busy),
    .done       (done)
  );

  // kind: 0 = no request, 1 = normal update, 2 = exception
  typedef struct {
    logic [7:0] req;   // {opc, ovf, div0, rte, jump, branch, imm, inc}
    int         kind;
    logic [2:0] sel;
    logic [1:0] cause;
  } vec_t;

  vec_t vecs[15];

  task automatic set_in(input logic [7:0] v);
    {exc_opcode, exc_ovf, exc_div0, req_rte, req_jump, req_branch, req_imm, req_inc} = v;
  endtask

  // Advance one clock and land 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, ".pc_src_sel"}, 32'(pc_src_sel), 32'd0);
    chk({nm, ".pulses"}, 32'({pc_write, epc_write, mem_rd, done}), 32'd0);
    chk({nm, ".busy"}, 32'(busy), 32'd0);
    chk({nm, ".vec_sel"}, 32'(vec_sel), 32'd0);
    chk({nm, ".exc_cause"}, 32'(exc_cause), 32'd0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", idx);
    set_in(v.req);
    step();
    set_in(8'h00);
    if (v.kind == 0) begin
      chk({tag, ".idle_pulses"}, 32'({pc_write, epc_write, mem_rd, done, busy}), 32'd0);
    end else if (v.kind == 1) begin
      chk({tag, ".upd_pc_write"}, 32'(pc_write), 32'd1);
      chk({tag, ".upd_done"}, 32'(done), 32'd1);
      chk({tag, ".upd_busy"}, 32'(busy), 32'd1);
      chk({tag, ".upd_epc_write"}, 32'(epc_write), 32'd0);
      chk({tag, ".upd_sel"}, 32'(pc_src_sel), 32'(v.sel));
      step();
      chk({tag, ".ret_pc_write"}, 32'(pc_write), 32'd0);
      chk({tag, ".ret_busy"}, 32'(busy), 32'd0);
      chk({tag, ".ret_sel_hold"}, 32'(pc_src_sel), 32'(v.sel));
    end else begin
      // EXC_EPC cycle; assert every input while busy to prove it is ignored
      chk({tag, ".cause"}, 32'(exc_cause), 32'(v.cause));
      chk({tag, ".epc_write"}, 32'(epc_write), 32'd1);
      chk({tag, ".epc_pc_write"}, 32'(pc_write), 32'd0);
      chk({tag, ".epc_busy"}, 32'(busy), 32'd1);
      set_in(8'hFF);
      for (int k = 0; k < int'(LAT); k++) begin
        step();
        chk($sformatf("%s.rd%0d_mem_rd", tag, k), 32'(mem_rd), 32'd1);
        chk($sformatf("%s.rd%0d_vec_sel", tag, k), 32'(vec_sel), 32'(v.cause));
        chk($sformatf("%s.rd%0d_writes", tag, k), 32'({pc_write, epc_write, done}), 32'd0);
      end
      step();
      chk({tag, ".load_sel"}, 32'(pc_src_sel), 32'd5);
      chk({tag, ".load_pc_write"}, 32'(pc_write), 32'd1);
      chk({tag, ".load_done"}, 32'(done), 32'd1);
      chk({tag, ".load_epc_write"}, 32'(epc_write), 32'd0);
      chk({tag, ".load_vec_sel"}, 32'(vec_sel), 32'(v.cause));
      set_in(8'h00);
      step();
      chk({tag, ".end_busy"}, 32'(busy), 32'd0);
      chk({tag, ".end_vec_mem"}, 32'({vec_sel, mem_rd}), 32'd0);
      chk({tag, ".end_pc_write"}, 32'(pc_write), 32'd0);
      chk({tag, ".end_cause_hold"}, 32'(exc_cause), 32'(v.cause));
    end
  endtask

  initial begin
    vecs[0]  = '{8'b0000_0001, 1, 3'b000, 2'b00};
    vecs[1]  = '{8'b0000_0100, 1, 3'b001, 2'b00};
    vecs[2]  = '{8'b0000_1000, 1, 3'b010, 2'b00};
    vecs[3]  = '{8'b0001_0000, 1, 3'b011, 2'b00};
    vecs[4]  = '{8'b0000_0010, 1, 3'b100, 2'b00};
    vecs[5]  = '{8'b0001_1100, 1, 3'b011, 2'b00};
    vecs[6]  = '{8'b0000_1000, 1, 3'b010, 2'b00};
    vecs[7]  = '{8'b0000_0111, 1, 3'b001, 2'b00};
    vecs[8]  = '{8'b0000_0011, 1, 3'b100, 2'b00};
    vecs[9]  = '{8'b0100_0001, 2, 3'b101, 2'b10};
    vecs[10] = '{8'b1010_0000, 2, 3'b101, 2'b01};
    vecs[11] = '{8'b0010_0000, 2, 3'b101, 2'b11};
    vecs[12] = '{8'b0011_0000, 2, 3'b101, 2'b11};
    vecs[13] = '{8'b0110_0000, 2, 3'b101, 2'b10};
    vecs[14] = '{8'b0000_0000, 0, 3'b000, 2'b00};

    reset = 1'b1;
    set_in(8'h00);
    repeat (3) step();
    chk_all_zero("reset");
    reset = 1'b0;
    repeat (5) step();
    chk_all_zero("idle5");

    for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);

    // Reset landing in the middle of the vector read aborts everything
    set_in(8'b0010_0000);
    step();
    set_in(8'h00);
    chk("mid.epc_write", 32'(epc_write), 32'd1);
    step();
    chk("mid.in_rd", 32'(mem_rd), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_all_zero("mid.reset");
    step();
    chk("mid.after_pulses", 32'({pc_write, epc_write, mem_rd, done, busy}), 32'd0);
    step();
    chk("mid.still_idle", 32'({pc_write, busy, vec_sel}), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_src_sequencer.md
Name: pc_src_sequencer

Overview:
- Sequences every PC update in the multicycle datapath by driving the 3-bit PC-source mux selector and the PC/EPC write enables.
- Arbitrates between the control unit's PC-update requests (PC+4, branch target, jump target, EPC return, sign-extended target) and the three exception events.
- Runs the full exception entry sequence: save EPC, read the handler vector byte from memory, load PC from it.
- Sits between the main control FSM and the PC/EPC registers and the memory address mux.

Parameters:
- MEM_LAT, 2, memory read latency in cycles from mem_rd assertion to valid mux_mem_out data (legal 1..7).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- req_inc  in  1  request PC <- PC+4
- req_branch  in  1  request PC <- ALUOut (taken branch)
- req_jump  in  1  request PC <- jump target (26->28 extended)
- req_rte  in  1  request PC <- EPC
- req_imm  in  1  request PC <- sign-extended value
- exc_opcode  in  1  invalid opcode event
- exc_ovf  in  1  arithmetic overflow event
- exc_div0  in  1  divide-by-zero event
- pc_src_sel  out  3  PC-source mux selector: 000 PC+4, 001 ALUOut, 010 jump, 011 EPC, 100 sign-ext, 101 memory byte
- pc_write  out  1  PC load enable, one-cycle pulse
- epc_write  out  1  EPC load enable, one-cycle pulse
- vec_sel  out  2  memory-address mux select for vector: 01 addr 253, 10 addr 254, 11 addr 255, 00 normal
- mem_rd  out  1  memory read strobe for vector fetch
- exc_cause  out  2  latched cause: 01 opcode, 10 overflow, 11 div0, 00 none
- busy  out  1  high while not IDLE
- done  out  1  one-cycle pulse in the cycle the PC is written

Behaviour:
- All outputs are registered.
- Reset: state IDLE; pc_src_sel=000; pc_write, epc_write, mem_rd, busy, done = 0; vec_sel=00; exc_cause=00.
- Reset mid-sequence aborts immediately with the same values. No partial EPC or PC write is allowed in the cycle after reset is sampled.
- States: IDLE, UPD, EXC_EPC, EXC_RD, EXC_LOAD.
- Inputs are sampled only in IDLE. All requests and events while busy=1 are ignored and not queued; the control unit holds them.
- Priority at the IDLE sample, highest first: exc_opcode > exc_ovf > exc_div0 > req_rte > req_jump > req_branch > req_imm > req_inc. Only the winner is serviced; losers are dropped.
- Normal request sampled at edge N:
  - Cycle N+1 is state UPD: pc_src_sel = winner's code, pc_write=1, done=1, busy=1.
  - Return to IDLE. Latency is 1 cycle.
- Exception sampled at edge N:
  - exc_cause latched per the priority order. It holds until the next exception or reset.
  - Cycle N+1 is EXC_EPC: epc_write=1, busy=1. EPC captures PC-4 from the datapath; the block drives nothing else for that path.
  - Cycles N+2 .. N+1+MEM_LAT are EXC_RD: mem_rd=1, vec_sel=exc_cause. A 3-bit down-counter is loaded with MEM_LAT-1 on entry and decremented each cycle; exit when it reaches 0.
  - Cycle N+2+MEM_LAT is EXC_LOAD: pc_src_sel=101, pc_write=1, done=1. vec_sel is held.
  - Then IDLE with vec_sel=00 and mem_rd=0.
  - Total latency is 2+MEM_LAT cycles.
- pc_src_sel holds its last value in IDLE; it is only meaningful when pc_write=1. Codes 110 and 111 are never driven.
- pc_write and epc_write are never both 1 in the same cycle.
- No request in IDLE: remain in IDLE with all pulses 0.

Decomposition:
- Shared package holds:
  - PC-source selector codes (PCSRC_INC=3'b000 .. PCSRC_MEM=3'b101).
  - Cause codes (CAUSE_NONE/OPC/OVF/DIV0).
  - Vector addresses 253/254/255.
  - State encoding.
- One natural sub-module: exc_priority_enc, a combinational 3-event -> 2-bit cause encoder, reused by the EPC/cause register logic.
- The FSM and latency counter stay in the top module.

Test Plan:
- Reset then idle 5 cycles -> all outputs 0, pc_src_sel=000, busy=0.
- req_inc=1 at edge 1 -> cycle 2: pc_write=1, pc_src_sel=000, done=1; cycle 3: pc_write=0, busy=0.
- req_branch, req_jump and req_rte all 1 together -> single UPD cycle with pc_src_sel=011. Hold only req_jump next IDLE -> pc_src_sel=010.
- exc_ovf=1 with req_inc=1, MEM_LAT=2:
  - Edge 1: cause latched, exc_cause=10.
  - Cycle 2: epc_write=1.
  - Cycles 3-4: mem_rd=1, vec_sel=10.
  - Cycle 5: pc_src_sel=101, pc_write=1, done=1.
  - The req_inc is not serviced.
- exc_div0 and exc_opcode together -> exc_cause=01, vec_sel=01. Requests asserted during cycles 2-4 are ignored.
- Reset asserted during EXC_RD -> next cycle IDLE, mem_rd=0, vec_sel=00, exc_cause=00, no pc_write pulse.
